mips32_mem_arbiter: RTL and testbench
=====================================

Name: mips32_mem_arbiter

Overview:
- Shares the single-port 1024x32 unified word memory between three requesters:
  - instruction fetch (IF, read-only);
  - MEM-stage data port (DM, load/store);
  - loader/debug port (LD, read/write, used to preload programs and inspect memory).
- Fixed-priority arbitration with a starvation guard for fetch.
- A four-state sequencer drives one memory transaction at a time and returns a per-requester ack.

Parameters:
- AW, 10, word-address width (1024 words)
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal range 1..15); read data is valid MEM_LAT cycles after the mem_en cycle
- STARVE_MAX, 4, consecutive lost arbitration decisions after which IF wins the next decision (legal range 1..15)

Ports:
- clk1  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- halted  in  1  processor halted; IF requests are ignored while high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch word address
- if_ack  out  1  one-cycle completion pulse to IF
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_ack  out  1  one-cycle completion pulse to DM
- ld_req  in  1  loader request, held until ld_ack
- ld_we  in  1  1=write, 0=read
- ld_addr  in  AW  loader word address
- ld_wdata  in  DW  loader write data
- ld_ack  out  1  one-cycle completion pulse to LD
- rdata  out  DW  registered read data, valid in the ack cycle of a read
- busy  out  1  high whenever state is not IDLE
- grant_id  out  2  0=IF, 1=DM, 2=LD; valid while busy
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (synchronous, also mid-transaction):
  - state returns to IDLE and any outstanding transaction is discarded; no ack is issued for it.
  - All acks, mem_en, mem_we, busy = 0.
  - grant_id, mem_addr, mem_wdata, rdata = 0.
  - Starvation counter = 0.
- States and transitions:
  - IDLE: arbitrate among active requests. With any winner, latch grant_id and the winner's we/addr/wdata into the mem_* registers, then go to ISSUE. With no request, stay in IDLE.
  - ISSUE: mem_en=1 for exactly this cycle. A write goes to RESP. A read goes to WAIT with cnt=MEM_LAT-1.
  - WAIT: when cnt==0, capture mem_rdata into rdata and go to RESP. Otherwise decrement cnt.
  - RESP: assert the ack of the granted requester for one cycle, then go to IDLE. Requests are not evaluated in RESP.
- Latency, with the request first seen in IDLE cycle T:
  - mem_en in cycle T+1.
  - Write ack in cycle T+2.
  - Read ack in cycle T+2+MEM_LAT (T+3 at the default).
  - rdata holds its value until the next read capture; writes leave rdata unchanged.
- Handshake:
  - A requester holds req and all fields stable until its ack.
  - A req still high in the cycle after ack is a new request.
  - The arbiter samples fields only in the IDLE decision cycle.
- Arbitration in IDLE:
  - Fixed priority: DM > LD > IF.
  - IF is eligible only if if_req && !halted.
  - Starvation counter increments when IF is eligible and loses, saturating at STARVE_MAX.
  - When counter==STARVE_MAX and IF is eligible, IF wins regardless of the others.
  - The counter clears whenever IF is granted or IF is not eligible.
- Simultaneous events: all three requests in the same cycle → DM granted. The others wait and are re-evaluated in the next IDLE cycle.
- halted rising during an IF transaction: the transaction completes and acks normally.
- grant_id and mem_* registers hold their values from ISSUE through RESP. mem_we is 0 whenever mem_en is 0.

Decomposition:
- Shared package mips32_mem_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - requester IDs: REQ_IF=2'd0, REQ_DM=2'd1, REQ_LD=2'd2;
  - default AW/DW constants.
- One natural sub-module, mips32_mem_prio_sel: combinational priority/starvation winner select plus the registered starvation counter.

Test Plan:
- Single IF read, addr=10'h005, mem_rdata returns 32'h2800_0001 → mem_en at T+1 with mem_addr=5, if_ack and rdata=32'h2800_0001 at T+3, busy high T+1..T+3.
- DM store: addr=10'h040, wdata=32'hDEAD_BEEF → mem_en=mem_we=1 at T+1 with those values, dm_ack at T+2, rdata unchanged.
- if_req, dm_req, ld_req all high at T → grant order DM, LD, IF; acks at T+3, T+7, T+11 (MEM_LAT=1, all reads).
- Starvation: dm_req held continuously for back-to-back loads with if_req high, STARVE_MAX=4 → IF is granted at the 5th decision, then DM resumes.
- halted=1 with if_req high for 20 cycles → no mem_en and no if_ack; deassert halted → if_ack 3 cycles later.
- rst asserted in WAIT with MEM_LAT=4 → next cycle state IDLE, busy=0, rdata=0, no ld_ack; a re-issued ld_req completes normally with ack at T+6.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter: sequencer states,
// requester IDs and default bus widths.
package mips32_mem_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_DM = 2'd1,
    REQ_LD = 2'd2
  } req_id_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter. The slave modport is the
// arbiter; the master modport is whoever drives requests and returns memory data.
interface mips32_mem_arbiter_if
  import mips32_mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          halted;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [1:0]    grant_id;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  if_ack, dm_ack, ld_ack, rdata, busy, grant_id,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output if_ack, dm_ack, ld_ack, rdata, busy, grant_id,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_mem_prio_sel.sv
// Fixed-priority winner select (DM > LD > IF) with a starvation counter that
// forces a fetch grant after STARVE_MAX consecutive lost decisions.
module mips32_mem_prio_sel
  import mips32_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic    clk1,
  input  logic    rst,
  input  logic    decide_i,
  input  logic    if_elig_i,
  input  logic    dm_req_i,
  input  logic    ld_req_i,
  output logic    valid_o,
  output req_id_e winner_o
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved = if_elig_i && (starve_q == SMAX);
  assign valid_o = if_elig_i | dm_req_i | ld_req_i;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    winner_o = REQ_IF;
    if (!starved) begin
      if (dm_req_i)      winner_o = REQ_DM;
      else if (ld_req_i) winner_o = REQ_LD;
    end
  end

  // Losses are counted only at decisions; an ineligible fetch clears the count at any time.
  always_comb begin
    starve_d = starve_q;
    if (!if_elig_i) begin
      starve_d = '0;
    end else if (decide_i) begin
      if (winner_o == REQ_IF)  starve_d = '0;
      else if (starve_q != SMAX) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Three-requester arbiter for the single-port unified word memory. One
// transaction at a time: IDLE decides, ISSUE strobes memory, WAIT counts read
// latency, RESP returns the ack.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                 clk1,
  input logic                 rst,
  mips32_mem_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  req_id_e       grant_q, grant_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic    if_elig;
  logic    sel_valid;
  req_id_e sel_id;

  assign if_elig = bus.if_req & ~bus.halted;

  mips32_mem_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio_sel (
    .clk1     (clk1),
    .rst      (rst),
    .decide_i (state_q == IDLE),
    .if_elig_i(if_elig),
    .dm_req_i (bus.dm_req),
    .ld_req_i (bus.ld_req),
    .valid_o  (sel_valid),
    .winner_o (sel_id)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d = sel_id;
          state_d = ISSUE;
          unique case (sel_id)
            REQ_DM: begin
              mem_we_d    = bus.dm_we;
              mem_addr_d  = bus.dm_addr;
              mem_wdata_d = bus.dm_wdata;
            end
            REQ_LD: begin
              mem_we_d    = bus.ld_we;
              mem_addr_d  = bus.ld_addr;
              mem_wdata_d = bus.ld_wdata;
            end
            default: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = bus.if_addr;
              mem_wdata_d = '0;
            end
          endcase
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= REQ_IF;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = grant_q;
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) & mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.if_ack    = (state_q == RESP) && (grant_q == REQ_IF);
  assign bus.dm_ack    = (state_q == RESP) && (grant_q == REQ_DM);
  assign bus.ld_ack    = (state_q == RESP) && (grant_q == REQ_LD);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1 and one at MEM_LAT=4, each backed
// by a small word memory whose read data arrives exactly MEM_LAT cycles after mem_en.
module tb_mips32_mem_arbiter;

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  mips32_mem_arbiter_if #(.AW(10), .DW(32)) ia ();
  mips32_mem_arbiter_if #(.AW(10), .DW(32)) ib ();

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk1(clk1), .rst(rst), .bus(ia)
  );
  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(4), .STARVE_MAX(4)) dut_b (
    .clk1(clk1), .rst(rst), .bus(ib)
  );

  // Memory A: one-cycle read latency
  logic [31:0] mem_a [1024];
  logic [31:0] rd_a;
  always @(posedge clk1) begin
    if (ia.mem_en) begin
      if (ia.mem_we) mem_a[ia.mem_addr] <= ia.mem_wdata;
      else           rd_a <= mem_a[ia.mem_addr];
    end
  end
  assign ia.mem_rdata = rd_a;

  // Memory B: four-cycle read latency
  logic [31:0] mem_b [1024];
  logic [31:0] rb1, rb2, rb3, rb4;
  always @(posedge clk1) begin
    if (ib.mem_en) begin
      if (ib.mem_we) mem_b[ib.mem_addr] <= ib.mem_wdata;
      else           rb1 <= mem_b[ib.mem_addr];
    end
    rb2 <= rb1;
    rb3 <= rb2;
    rb4 <= rb3;
  end
  assign ib.mem_rdata = rb4;

  logic [2:0] acks_a, acks_b;
  assign acks_a = {ia.ld_ack, ia.dm_ack, ia.if_ack};
  assign acks_b = {ib.ld_ack, ib.dm_ack, ib.if_ack};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_ack;
    int         seen;

    rst = 1'b1;
    ia.halted = 0; ia.if_req = 0; ia.if_addr = '0;
    ia.dm_req = 0; ia.dm_we = 0; ia.dm_addr = '0; ia.dm_wdata = '0;
    ia.ld_req = 0; ia.ld_we = 0; ia.ld_addr = '0; ia.ld_wdata = '0;
    ib.halted = 0; ib.if_req = 0; ib.if_addr = '0;
    ib.dm_req = 0; ib.dm_we = 0; ib.dm_addr = '0; ib.dm_wdata = '0;
    ib.ld_req = 0; ib.ld_we = 0; ib.ld_addr = '0; ib.ld_wdata = '0;
    tick(2);

    check("rst_busy",   32'(ia.busy), 32'd0);
    check("rst_grant",  32'(ia.grant_id), 32'd0);
    check("rst_maddr",  32'(ia.mem_addr), 32'd0);
    check("rst_mwdata", ia.mem_wdata, 32'd0);
    check("rst_rdata",  ia.rdata, 32'd0);
    check("rst_strobe", 32'({ia.mem_en, ia.mem_we, acks_a}), 32'd0);
    rst = 1'b0;
    tick();

    // Preload word 5 through the loader port
    ia.ld_req = 1; ia.ld_we = 1; ia.ld_addr = 10'h005; ia.ld_wdata = 32'h2800_0001;
    tick();
    check("ld_wr_issue", 32'({ia.mem_en, ia.mem_we, ia.grant_id}), 32'b1110);
    check("ld_wr_addr",  32'(ia.mem_addr), 32'h005);
    tick();
    check("ld_wr_ack", 32'(acks_a), 32'b100);
    ia.ld_req = 0; ia.ld_we = 0;
    tick();
    check("ld_wr_idle", 32'(ia.busy), 32'd0);

    // Single fetch read
    ia.if_req = 1; ia.if_addr = 10'h005;
    tick();
    check("if_rd_en",   32'({ia.mem_en, ia.mem_we, ia.busy}), 32'b101);
    check("if_rd_addr", 32'(ia.mem_addr), 32'h005);
    tick();
    check("if_rd_t2",   32'({ia.busy, ia.mem_en, acks_a}), 32'b10000);
    tick();
    check("if_rd_ack",  32'({ia.busy, acks_a}), 32'b1001);
    check("if_rd_data", ia.rdata, 32'h2800_0001);
    ia.if_req = 0;
    tick();
    check("if_rd_done", 32'({ia.busy, acks_a}), 32'd0);

    // Data store
    ia.dm_req = 1; ia.dm_we = 1; ia.dm_addr = 10'h040; ia.dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("dm_st_issue", 32'({ia.mem_en, ia.mem_we, ia.grant_id}), 32'b1101);
    check("dm_st_addr",  32'(ia.mem_addr), 32'h040);
    check("dm_st_wdata", ia.mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("dm_st_ack",   32'({ia.mem_en, ia.mem_we, acks_a}), 32'b00010);
    check("dm_st_rdata", ia.rdata, 32'h2800_0001);
    ia.dm_req = 0; ia.dm_we = 0;
    tick();
    check("dm_st_done", 32'(ia.busy), 32'd0);

    // All three read together: DM, then LD, then IF
    ia.if_req = 1; ia.if_addr = 10'h040;
    ia.dm_req = 1; ia.dm_addr = 10'h040;
    ia.ld_req = 1; ia.ld_addr = 10'h005;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_ack = (k == 3) ? 3'b010 : (k == 7) ? 3'b100 : (k == 11) ? 3'b001 : 3'b000;
      check($sformatf("arb3_ack_k%0d", k), 32'(acks_a), 32'(exp_ack));
      if (k == 1) check("arb3_grant1", 32'(ia.grant_id), 32'd1);
      if (k == 5) check("arb3_grant2", 32'(ia.grant_id), 32'd2);
      if (k == 9) check("arb3_grant3", 32'(ia.grant_id), 32'd0);
      if (k == 3)  begin check("arb3_dm_data", ia.rdata, 32'hDEAD_BEEF); ia.dm_req = 0; end
      if (k == 7)  begin check("arb3_ld_data", ia.rdata, 32'h2800_0001); ia.ld_req = 0; end
      if (k == 11) begin check("arb3_if_data", ia.rdata, 32'hDEAD_BEEF); ia.if_req = 0; end
    end
    tick();
    check("arb3_done", 32'(ia.busy), 32'd0);

    // Starvation: back-to-back DM loads with a fetch pending
    ia.dm_req = 1; ia.dm_we = 0; ia.dm_addr = 10'h040;
    ia.if_req = 1; ia.if_addr = 10'h005;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k % 4 == 1) begin
        check($sformatf("starve_en_k%0d", k), 32'(ia.mem_en), 32'd1);
        check($sformatf("starve_grant_k%0d", k), 32'(ia.grant_id), (k == 17) ? 32'd0 : 32'd1);
      end
      if (k % 4 == 3) begin
        exp_ack = (k == 19) ? 3'b001 : 3'b010;
        check($sformatf("starve_ack_k%0d", k), 32'(acks_a), 32'(exp_ack));
        if (k == 19) ia.if_req = 0;
        if (k == 23) ia.dm_req = 0;
      end
    end
    tick();
    check("starve_done", 32'(ia.busy), 32'd0);

    // Halted blocks fetch; halted rising mid-transaction does not
    ia.halted = 1; ia.if_req = 1; ia.if_addr = 10'h005;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ia.mem_en || ia.if_ack || ia.busy) seen++;
    end
    check("halt_quiet", 32'(seen), 32'd0);
    ia.halted = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("unhalt_ack_k%0d", k), 32'(ia.if_ack), (k == 3) ? 32'd1 : 32'd0);
      if (k == 1) ia.halted = 1;
      if (k == 3) begin check("unhalt_data", ia.rdata, 32'h2800_0001); ia.if_req = 0; end
    end
    ia.halted = 0;

    // MEM_LAT=4 instance: write, full read, then reset during WAIT
    ib.ld_req = 1; ib.ld_we = 1; ib.ld_addr = 10'h007; ib.ld_wdata = 32'hCAFE_0007;
    tick();
    check("b_wr_issue", 32'({ib.mem_en, ib.mem_we, ib.grant_id}), 32'b1110);
    tick();
    check("b_wr_ack", 32'(acks_b), 32'b100);
    ib.ld_req = 0; ib.ld_we = 0;
    tick();
    ib.ld_req = 1; ib.ld_addr = 10'h007;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("b_rd_ack_k%0d", k), 32'(ib.ld_ack), (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) begin check("b_rd_data", ib.rdata, 32'hCAFE_0007); ib.ld_req = 0; end
    end
    tick();
    ib.ld_req = 1; ib.ld_addr = 10'h007;
    tick(3);
    check("b_in_wait", 32'({ib.busy, ib.mem_en}), 32'b10);
    rst = 1'b1;
    tick();
    check("b_rst_busy",  32'(ib.busy), 32'd0);
    check("b_rst_rdata", ib.rdata, 32'd0);
    check("b_rst_ack",   32'(acks_b), 32'd0);
    check("b_rst_maddr", 32'(ib.mem_addr), 32'd0);
    tick();
    check("b_rst_hold", 32'({ib.busy, acks_b}), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("b_reissue_ack_k%0d", k), 32'(ib.ld_ack), (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) begin check("b_reissue_data", ib.rdata, 32'hCAFE_0007); ib.ld_req = 0; end
    end
    check("b_final_idle", 32'(ib.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
